// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - BHT direction predictor with EX-stage branch resolution
//
// Purpose:
//   2-bit saturating-counter BHT read combinationally at fetch, with branch
//   resolution at EX from func3 and ALU flags. Also performs the BHT update,
//   drives a registered mispredict redirect and keeps saturating statistics.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   if_pc                  fetch PC for lookup
//   if_pred_taken          combinational prediction (counter MSB)
//   ex_valid, ex_branch    EX holds a valid conditional branch
//   ex_func3               branch condition select
//   ex_zf/cf/vf/sf         flags of rs1 - rs2 (cf = borrow)
//   ex_pred_taken          prediction carried with the branch
//   ex_pc, ex_target       branch PC and taken target
//   stall, flush_in        hold / squash of the EX instruction
//   ex_taken               combinational resolved direction
//   redirect_valid/pc      registered mispredict redirect
//   br_count, mispred_count  saturating statistics
module branch_predict_resolve #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_LSB   = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_func3,
  input  logic             ex_zf,
  input  logic             ex_cf,
  input  logic             ex_vf,
  input  logic             ex_sf,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  input  logic             flush_in,
  output logic             ex_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic             redirect_valid_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mispred_count_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             dir;
  logic             legal;
  logic             res;
  logic             mispredict;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_d;
  logic [XLEN-1:0]  redirect_pc_d;

  // Only the index bits of the fetch PC matter; no tags are kept.
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;

  assign if_idx        = if_pc[INDEX_LSB +: IDX_W];
  assign ex_idx        = ex_pc[INDEX_LSB +: IDX_W];
  // Reads the registered array, so a same-cycle update is not visible yet.
  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    dir = 1'b0;
    case (ex_func3)
      3'b000:  dir = ex_zf;
      3'b001:  dir = ~ex_zf;
      3'b100:  dir = ex_sf ^ ex_vf;
      3'b101:  dir = ~(ex_sf ^ ex_vf);
      3'b110:  dir = ex_cf;
      3'b111:  dir = ~ex_cf;
      default: dir = 1'b0;
    endcase
  end

  assign legal      = (ex_func3 != 3'b010) && (ex_func3 != 3'b011);
  assign ex_taken   = ex_valid & ex_branch & dir;
  // flush_in squashes the branch outright; stall defers it to the release cycle.
  assign res        = ex_valid & ex_branch & ~stall & ~flush_in;
  assign mispredict = res & (ex_taken != ex_pred_taken);

  assign redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);

  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_d   = bht_cur;
    if (ex_taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      mispred_count_q  <= '0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= redirect_pc_d;
        if (mispred_count_q != {CNT_W{1'b1}}) mispred_count_q <= mispred_count_q + CNT_W'(1);
      end
      if (res && legal) begin
        bht_q[ex_idx] <= bht_d;
        if (br_count_q != {CNT_W{1'b1}}) br_count_q <= br_count_q + CNT_W'(1);
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;

endmodule
